// File: rtl/dvsd_8216m9_mac.sv
// Frame multiply-accumulate: sums A*B over a LAST-terminated frame and presents
// the sum, pair count and overflow flag through a valid/ready output.

module dvsd_8216m9 (
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] M
);
  assign M = 16'(A) * 16'(B);
endmodule

module dvsd_8216m9_mac #(
  parameter int ACC_W = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic             LAST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [ACC_W-1:0] RES,
  output logic [7:0]       CNT,
  output logic             OVF,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  typedef enum logic {ST_ACC, ST_HOLD} state_e;

  state_e             state_q, state_d;
  logic               p_valid_q, p_valid_d;
  logic [15:0]        p_q, p_d;
  logic               p_last_q, p_last_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]         cnt_acc_q, cnt_acc_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [ACC_W-1:0]   res_q, res_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;

  logic [15:0]        prod;
  logic               in_ready;
  logic               in_fire;
  logic [ACC_W:0]     sum_w;
  logic [7:0]         cnt_inc;
  logic               ovf_inc;

  dvsd_8216m9 u_mul (
    .A (A),
    .B (B),
    .M (prod)
  );

  // Once a LAST product is in flight no further pair may enter until the frame closes.
  assign in_ready = (state_q == ST_ACC) && !p_last_q && !RST;
  assign in_fire  = IN_VALID && in_ready;

  // Extra top bit captures the carry out of the accumulator.
  assign sum_w   = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, p_q};
  assign cnt_inc = (cnt_acc_q == 8'hFF) ? 8'hFF : cnt_acc_q + 8'd1;
  assign ovf_inc = ovf_acc_q | sum_w[ACC_W];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_acc_d   = cnt_acc_q;
    ovf_acc_d   = ovf_acc_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    p_valid_d = in_fire;
    p_d       = in_fire ? prod : p_q;
    p_last_d  = in_fire && LAST;

    case (state_q)
      ST_ACC: begin
        if (p_valid_q) begin
          if (p_last_q) begin
            res_d       = sum_w[ACC_W-1:0];
            cnt_d       = cnt_inc;
            ovf_d       = ovf_inc;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_acc_d   = '0;
            ovf_acc_d   = 1'b0;
            state_d     = ST_HOLD;
          end else begin
            acc_d     = sum_w[ACC_W-1:0];
            cnt_acc_d = cnt_inc;
            ovf_acc_d = ovf_inc;
          end
        end
      end
      ST_HOLD: begin
        if (out_valid_q && OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_ACC;
      p_valid_q   <= 1'b0;
      p_q         <= '0;
      p_last_q    <= 1'b0;
      acc_q       <= '0;
      cnt_acc_q   <= '0;
      ovf_acc_q   <= 1'b0;
      res_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_valid_q   <= p_valid_d;
      p_q         <= p_d;
      p_last_q    <= p_last_d;
      acc_q       <= acc_d;
      cnt_acc_q   <= cnt_acc_d;
      ovf_acc_q   <= ovf_acc_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY  = in_ready;
  assign RES       = res_q;
  assign CNT       = cnt_q;
  assign OVF       = ovf_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_dvsd_8216m9_mac.sv
// Directed bench for dvsd_8216m9_mac: frames are driven, expected results queued
// from a reference sum, and popped when the DUT presents OUT_VALID.

module tb_dvsd_8216m9_mac;
  localparam int ACC_W = 24;

  logic             CLK = 1'b0;
  logic             RST;
  logic [7:0]       A, B;
  logic             LAST, IN_VALID, IN_READY;
  logic [ACC_W-1:0] RES;
  logic [7:0]       CNT;
  logic             OVF, OUT_VALID, OUT_READY;

  typedef struct packed {
    logic [ACC_W-1:0] res;
    logic [7:0]       cnt;
    logic             ovf;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fa[$], fb[$];
  int         tests = 0;
  int         failed = 0;
  int         cyc = 0;
  int         last_cyc = 0;

  dvsd_8216m9_mac #(.ACC_W(ACC_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .LAST      (LAST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .RES       (RES),
    .CNT       (CNT),
    .OVF       (OVF),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill_const(input int n, input logic [7:0] a, input logic [7:0] b);
    fa.delete();
    fb.delete();
    for (int i = 0; i < n; i++) begin
      fa.push_back(a);
      fb.push_back(b);
    end
  endtask

  task automatic push_expected();
    longint unsigned total = 0;
    exp_t e;
    int n = fa.size();
    for (int i = 0; i < n; i++) total += longint'(fa[i]) * longint'(fb[i]);
    e.res = total[ACC_W-1:0];
    e.ovf = (total >= (64'd1 << ACC_W));
    e.cnt = (n > 255) ? 8'd255 : 8'(n);
    sb.push_back(e);
  endtask

  task automatic send_frame(input string tag);
    int n = fa.size();
    int bubbles = 0;
    int w;
    push_expected();
    for (int i = 0; i < n; i++) begin
      A = fa[i];
      B = fb[i];
      LAST = (i == n - 1);
      IN_VALID = 1'b1;
      w = 0;
      while (!IN_READY && w < 50) begin
        step();
        w++;
      end
      if (w >= 50) begin
        chk({tag, "_in_timeout"}, 0, 1);
        break;
      end
      if (i > 0) bubbles += w;
      if (i == n - 1) last_cyc = cyc;
      step();
    end
    IN_VALID = 1'b0;
    LAST = 1'b0;
    chk({tag, "_no_bubbles"}, bubbles, 0);
  endtask

  task automatic get_result(input string tag, input bit do_handshake);
    int w = 0;
    exp_t e;
    while (!OUT_VALID && w < 20) begin
      step();
      w++;
    end
    if (w >= 20) begin
      chk({tag, "_out_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_latency"}, cyc - last_cyc, 2);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_res"}, RES, e.res);
    chk({tag, "_cnt"}, CNT, e.cnt);
    chk({tag, "_ovf"}, OVF, e.ovf);
    if (do_handshake) begin
      OUT_READY = 1'b1;
      step();
      OUT_READY = 1'b0;
      chk({tag, "_ready_after"}, IN_READY, 1);
      chk({tag, "_valid_clr"}, OUT_VALID, 0);
    end
  endtask

  initial begin
    logic [ACC_W-1:0] res0;
    logic [7:0]       cnt0;
    logic             ovf0;
    bit               stable;
    bit               seen;

    RST = 1'b1;
    A = '0;
    B = '0;
    LAST = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    step();
    step();
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_res", RES, 0);
    chk("rst_cnt", CNT, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    RST = 1'b0;
    #1;
    chk("post_rst_in_ready", IN_READY, 1);

    fill_const(1, 8'd3, 8'd5);
    send_frame("single");
    get_result("single", 1);

    fill_const(3, 8'hFF, 8'hFF);
    send_frame("three_ff");
    get_result("three_ff", 1);

    fill_const(258, 8'hFF, 8'hFF);
    send_frame("ff258");
    get_result("ff258", 1);

    fill_const(259, 8'hFF, 8'hFF);
    send_frame("ff259");
    get_result("ff259", 1);

    fa.delete();
    fb.delete();
    for (int i = 0; i < 6; i++) begin
      fa.push_back(8'($urandom_range(0, 255)));
      fb.push_back(8'($urandom_range(0, 255)));
    end
    send_frame("rand6");
    get_result("rand6", 1);

    // Output stall: a pending pair must not enter until the result is taken.
    fa = '{8'd4, 8'd6};
    fb = '{8'd5, 8'd7};
    send_frame("hold");
    get_result("hold", 0);
    res0 = RES;
    cnt0 = CNT;
    ovf0 = OVF;
    A = 8'd9;
    B = 8'd9;
    LAST = 1'b1;
    IN_VALID = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || RES !== res0 || CNT !== cnt0 || OVF !== ovf0)
        stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    chk("hold_release_ready", IN_READY, 1);
    fa = '{8'd9};
    fb = '{8'd9};
    push_expected();
    last_cyc = cyc;
    step();
    IN_VALID = 1'b0;
    LAST = 1'b0;
    get_result("after_hold", 1);

    // Reset in the middle of a frame discards the partial sum.
    A = 8'd10;
    B = 8'd10;
    LAST = 1'b0;
    IN_VALID = 1'b1;
    step();
    A = 8'd11;
    step();
    A = 8'd12;
    RST = 1'b1;
    #1;
    chk("rst_priority_ready", IN_READY, 0);
    step();
    RST = 1'b0;
    IN_VALID = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (OUT_VALID !== 1'b0) seen = 1'b1;
      step();
    end
    chk("midrst_no_out", seen, 0);
    chk("midrst_cnt", CNT, 0);
    fa = '{8'd2, 8'd1};
    fb = '{8'd7, 8'd1};
    send_frame("midrst");
    get_result("midrst", 1);

    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dvsd_8216m9_mac.md
DVSD_8216M9_MAC -- requirements
Module: dvsd_8216m9_mac

Interface
REQ-001 SHALL have parameter ACC_W, default 24, meaning accumulator and result width in bits (legal range 17..32).
REQ-002 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  synchronous active-high reset.
REQ-004 SHALL have port A  input  8  unsigned multiplicand of the current input pair.
REQ-005 SHALL have port B  input  8  unsigned multiplier of the current input pair.
REQ-006 SHALL have port LAST  input  1  marks the current pair as the final pair of a frame.
REQ-007 SHALL have port IN_VALID  input  1  A/B/LAST are valid.
REQ-008 SHALL have port IN_READY  output  1  block accepts the pair this cycle.
REQ-009 SHALL have port RES  output  ACC_W  frame sum of A*B products.
REQ-010 SHALL have port CNT  output  8  number of pairs in the frame, saturating at 255.
REQ-011 SHALL have port OVF  output  1  frame sum exceeded 2^ACC_W-1.
REQ-012 SHALL have port OUT_VALID  output  1  RES/CNT/OVF are valid.
REQ-013 SHALL have port OUT_READY  input  1  downstream accepts the result.

Function
REQ-014 SHALL compute each 16-bit product with an instance of the team 8x8 multiplier dvsd_8216m9 (ports A, B, M).
REQ-015 SHALL perform an input transfer only when IN_VALID=1 and IN_READY=1 in the same cycle.
REQ-016 SHALL register each transfer into a product stage: p_valid=1, p=A*B, p_last=LAST.
REQ-017 SHALL update state in the cycle after a transfer when p_valid=1: acc <= (acc + zero-extended p) mod 2^ACC_W, CNT increments (holds at 255), OVF latches 1 on carry out of bit ACC_W-1.
REQ-018 SHALL use two states, ACC and HOLD; ACC is entered on reset.
REQ-019 SHALL drive IN_READY = 1 only when state=ACC, p_last=0 and RST=0.
REQ-020 SHALL, when p_valid=1 and p_last=1, load RES with the final sum, load CNT and OVF including that product, set OUT_VALID=1, clear acc/CNT/OVF accumulation registers, and move to HOLD.
REQ-021 SHALL assert OUT_VALID exactly 2 cycles after the LAST transfer (transfer at cycle n, OUT_VALID high from cycle n+2).
REQ-022 SHALL hold RES, CNT, OVF and OUT_VALID stable in HOLD until OUT_VALID=1 and OUT_READY=1; on that cycle, clear OUT_VALID and return to ACC at the next edge. IN_READY SHALL be 1 in the following cycle.
REQ-023 SHALL treat a single-pair frame (LAST on the first pair) as a valid frame with CNT=1.
REQ-024 SHALL accept back-to-back transfers every cycle within a frame with no bubbles.
REQ-025 SHALL not consume or alter any pair presented while IN_READY=0.

Reset
REQ-026 SHALL, on any rising edge with RST=1, regardless of state or mid-frame progress, set state=ACC, acc=0, p_valid=0, p_last=0, RES=0, CNT=0, OVF=0 and OUT_VALID=0, and discard any partial frame.
REQ-027 SHALL give RST priority over all handshakes in the same cycle.

Verification
REQ-028 Single pair A=3, B=5, LAST=1 -> OUT_VALID at cycle n+2; RES=15, CNT=1, OVF=0.
REQ-029 Three pairs A=B=0xFF, LAST on the third -> RES=195075, CNT=3, OVF=0.
REQ-030 259 pairs A=B=0xFF, ACC_W=24 -> RES=64259, CNT=255, OVF=1; with 258 pairs -> RES=16776450, OVF=0.
REQ-031 Hold OUT_READY=0 for 5 cycles after OUT_VALID with IN_VALID=1 -> IN_READY=0 and RES/CNT/OVF stable throughout; the next frame starts only after the OUT_READY handshake.
REQ-032 Pulse RST after 2 of 4 pairs of a frame -> no OUT_VALID; a subsequent frame A=2, B=7 then A=1, B=1 with LAST -> RES=15, CNT=2.
